// File: rtl/pingpong_block_drain_pkg.sv
// Shared definitions for the ping-pong block drain stage: FSM encoding and
// a counter-width helper.
package pingpong_block_drain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_RELEASE = 2'd3
    } drain_state_e;

    // Bits needed for a counter that must hold the value n itself.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pingpong_drain_skid_fifo.sv
// Two-entry {data,last} skid FIFO with occupancy output. Push and pop in the
// same cycle leave the count unchanged; the head is stable while not popped.
module pingpong_drain_skid_fifo #(
    parameter int DataWidth = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] push_data_i,
    input  logic                 push_last_i,
    input  logic                 pop_i,
    output logic                 valid_o,
    output logic [DataWidth-1:0] head_data_o,
    output logic                 head_last_o,
    output logic [1:0]           count_o
);

    logic [DataWidth-1:0] data_q [2];
    logic [1:0]           last_q;
    logic                 wr_ptr_q;
    logic                 rd_ptr_q;
    logic [1:0]           count_q;
    logic                 do_push;
    logic                 do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    // A push into a full FIFO is only legal when the head leaves this cycle.
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            last_q    <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (do_push) begin
                data_q[wr_ptr_q] <= push_data_i;
                last_q[wr_ptr_q] <= push_last_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign valid_o     = (count_q != 2'd0);
    assign head_data_o = data_q[rd_ptr_q];
    assign head_last_o = last_q[rd_ptr_q];
    assign count_o     = count_q;

endmodule

// File: rtl/pingpong_block_drain.sv
// Consumer stage for the ping-pong channel: reads one committed buffer in
// address order, streams it out with a last marker, then releases it.
// Optional block checksum output is enabled with the BLOCK_SUM_EN macro.
module pingpong_block_drain
    import pingpong_block_drain_pkg::*;
#(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 3,
    parameter int BlockLen     = 8,
    localparam int CntW        = cnt_width(BlockLen)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    t_empty_n,
    output logic                    t_ce,
    output logic                    t_read,
    output logic                    t_ce0,
    output logic                    t_we0,
    output logic [AddressWidth-1:0] t_address0,
    output logic [DataWidth-1:0]    t_d0,
    input  logic [DataWidth-1:0]    t_q0,
    output logic [DataWidth-1:0]    out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
`ifdef BLOCK_SUM_EN
    output logic [DataWidth-1:0]    sum_data,
    output logic                    sum_valid,
`endif
    output logic [1:0]              dbg_state_o,
    output logic [CntW-1:0]         dbg_sent_o
);

    // Stream handshake: a word transfers on a cycle with out_valid & out_ready;
    // out_valid never drops and out_data/out_last never change until it does.

    localparam logic [AddressWidth-1:0] LastAddr = AddressWidth'(BlockLen - 1);

    drain_state_e          state_q, state_d;
    logic [AddressWidth-1:0] rd_addr_q, rd_addr_d;
    logic [CntW-1:0]       sent_q, sent_d;
    logic                  inflight_q;
    logic                  inflight_last_q;
    logic [1:0]            fifo_count;
    logic                  fifo_valid;
    logic                  fifo_last;
    logic [DataWidth-1:0]  fifo_data;
    logic [2:0]            occupancy;
    logic                  out_hs;
    logic                  credit_ok;
    logic                  issue;
    logic                  issue_last;

    assign out_hs    = fifo_valid && out_ready;
    // Words queued plus the read in flight may not exceed the FIFO depth,
    // counting the slot freed by a handshake in the same cycle.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};
    assign credit_ok = (occupancy < 3'd2) || ((occupancy == 3'd2) && out_hs);
    assign issue      = (state_q == ST_READ) && credit_ok;
    assign issue_last = issue && (rd_addr_q == LastAddr);

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        sent_d    = sent_q;
        t_ce      = 1'b0;
        t_read    = 1'b0;
        if (out_hs) begin
            sent_d = sent_q + CntW'(1);
        end
        case (state_q)
            ST_IDLE: begin
                if (t_empty_n) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (issue_last) begin
                    state_d = ST_DRAIN;
                end else if (issue) begin
                    rd_addr_d = rd_addr_q + AddressWidth'(1);
                end
            end
            ST_DRAIN: begin
                if (out_hs && fifo_last) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                t_ce      = 1'b1;
                t_read    = 1'b1;
                rd_addr_d = '0;
                sent_d    = '0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            rd_addr_q       <= '0;
            sent_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            rd_addr_q       <= rd_addr_d;
            sent_q          <= sent_d;
            inflight_q      <= issue;
            inflight_last_q <= issue_last;
        end
    end

    // Memory data arrives one cycle after the read and is pushed immediately.
    pingpong_drain_skid_fifo #(
        .DataWidth (DataWidth)
    ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .push_i      (inflight_q),
        .push_data_i (t_q0),
        .push_last_i (inflight_last_q),
        .pop_i       (out_ready),
        .valid_o     (fifo_valid),
        .head_data_o (fifo_data),
        .head_last_o (fifo_last),
        .count_o     (fifo_count)
    );

    assign t_ce0      = issue;
    assign t_address0 = issue ? rd_addr_q : '0;
    assign t_we0      = 1'b0;
    assign t_d0       = '0;
    assign out_valid  = fifo_valid;
    assign out_data   = fifo_data;
    assign out_last   = fifo_last;

`ifdef BLOCK_SUM_EN
    logic [DataWidth-1:0] acc_q;

    always_ff @(posedge clk) begin
        if (reset || (state_q == ST_RELEASE)) begin
            acc_q <= '0;
        end else if (out_hs) begin
            acc_q <= acc_q + fifo_data;
        end
    end

    assign sum_valid = (state_q == ST_RELEASE);
    assign sum_data  = sum_valid ? acc_q : '0;
`endif

    assign dbg_state_o = state_q;
    assign dbg_sent_o  = sent_q;

endmodule

// File: tb/tb_pingpong_block_drain.sv
// Self-checking bench for pingpong_block_drain: a channel/memory model, a
// block-level scoreboard, directed latency cases and randomized traffic.
`timescale 1ns/1ps
module tb_pingpong_block_drain;

    localparam int DW = 32;
    localparam int AW = 3;
    localparam int BL = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    // ---------------- main DUT (BlockLen = 8) ----------------
    logic          t_empty_n, t_ce, t_read, t_ce0, t_we0;
    logic [AW-1:0] t_address0;
    logic [DW-1:0] t_d0;
    logic [DW-1:0] t_q0 = '0;
    logic [DW-1:0] out_data;
    logic          out_valid, out_last;
    logic          out_ready = 1'b1;
    logic [1:0]    dbg_state;
    logic [3:0]    dbg_sent;
`ifdef BLOCK_SUM_EN
    logic [DW-1:0] sum_data;
    logic          sum_valid;
`endif

    pingpong_block_drain #(.DataWidth(DW), .AddressWidth(AW), .BlockLen(BL)) dut (
        .clk(clk), .reset(reset), .t_empty_n(t_empty_n),
        .t_ce(t_ce), .t_read(t_read), .t_ce0(t_ce0), .t_we0(t_we0),
        .t_address0(t_address0), .t_d0(t_d0), .t_q0(t_q0),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last),
`ifdef BLOCK_SUM_EN
        .sum_data(sum_data), .sum_valid(sum_valid),
`endif
        .dbg_state_o(dbg_state), .dbg_sent_o(dbg_sent)
    );

    // ---------------- second DUT (BlockLen = 1) ----------------
    logic          e1, ce1, rd1s, ce01, we01;
    logic [AW-1:0] addr1;
    logic [DW-1:0] d01, data1;
    logic [DW-1:0] q1 = '0;
    logic          valid1, last1;
    logic          rdy1 = 1'b1;
    logic [1:0]    dbg_state1;
    logic [0:0]    dbg_sent1;
`ifdef BLOCK_SUM_EN
    logic [DW-1:0] sum1_data;
    logic          sum1_valid;
`endif

    pingpong_block_drain #(.DataWidth(DW), .AddressWidth(AW), .BlockLen(1)) dut1 (
        .clk(clk), .reset(reset), .t_empty_n(e1),
        .t_ce(ce1), .t_read(rd1s), .t_ce0(ce01), .t_we0(we01),
        .t_address0(addr1), .t_d0(d01), .t_q0(q1),
        .out_data(data1), .out_valid(valid1), .out_ready(rdy1),
        .out_last(last1),
`ifdef BLOCK_SUM_EN
        .sum_data(sum1_data), .sum_valid(sum1_valid),
`endif
        .dbg_state_o(dbg_state1), .dbg_sent_o(dbg_sent1)
    );

    // ---------------- channel models ----------------
    logic [DW-1:0] chan_mem [8][BL];
    int wr_cnt = 0;
    int rd_cnt = 0;
    assign t_empty_n = (wr_cnt != rd_cnt);

    always @(posedge clk) begin
        if (reset) rd_cnt <= wr_cnt;
        else if (t_ce && t_read) rd_cnt <= rd_cnt + 1;
        t_q0 <= t_ce0 ? chan_mem[rd_cnt % 8][t_address0] : DW'($urandom());
    end

    int wr1 = 0;
    int rd1 = 0;
    assign e1 = (wr1 != rd1);

    always @(posedge clk) begin
        if (reset) rd1 <= wr1;
        else if (ce1 && rd1s) rd1 <= rd1 + 1;
        q1 <= ce01 ? 32'hDEADBEEF : DW'($urandom());
    end

    // ---------------- scoreboard state ----------------
    logic [DW:0]   exp_q[$];
    logic [DW-1:0] blk_w [BL];
    int            ce0_cyc[$];
    int            hs_cyc[$];
    int            rel_cyc[$];
    logic [DW-1:0] hs_data[$];
    int            last_n = 0;
    int            rel_total = 0;
    logic [DW-1:0] last_sum = '0;
    int            ce01_n = 0, hs1_n = 0, rel1_n = 0;
    logic [DW-1:0] hs1_data = '0;
    logic          hs1_last = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- compare process ----------------
    int            issued = 0;
    int            sent = 0;
    logic [DW-1:0] blk_sum = '0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    logic          prev_rel = 1'b0;
    logic          prev_reset = 1'b1;
    logic [DW:0]   e;
    logic          hs;

    always @(negedge clk) begin
        if (prev_reset) begin
            check("reset_outputs",
                  {32'd0, |{t_ce, t_read, t_ce0, t_we0, t_address0, t_d0, out_valid, out_data,
                    out_last, dbg_state, dbg_sent, ce1, rd1s, ce01, valid1, data1, last1}},
                  64'd0);
`ifdef BLOCK_SUM_EN
            check("reset_sum", {31'd0, sum_valid, sum_data}, 64'd0);
`endif
            issued = 0;
            sent = 0;
            blk_sum = '0;
            prev_stall = 1'b0;
            prev_rel = 1'b0;
        end else begin
            hs = out_valid && out_ready;
            check("tied_write_port", {31'd0, t_we0 | we01, t_d0 | d01}, 64'd0);
            if (prev_stall)
                check("stall_hold", {31'd0, out_valid, out_last, out_data}, {31'd0, 1'b1, prev_last, prev_data});
            if (t_ce0) begin
                ce0_cyc.push_back(cyc);
                check("rd_addr", 64'(t_address0), 64'(issued));
                check("credit", 64'((issued + 1 - sent - (hs ? 1 : 0)) <= 2), 64'd1);
                check("issue_budget", 64'(issued < BL), 64'd1);
                issued++;
            end
            if (hs) begin
                hs_cyc.push_back(cyc);
                hs_data.push_back(out_data);
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {31'd0, out_last, out_data}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_word", {31'd0, out_last, out_data}, {31'd0, e});
                    blk_sum = blk_sum + e[DW-1:0];
                end
                if (out_last) last_n++;
                sent++;
            end
            if (t_ce || t_read) begin
                rel_cyc.push_back(cyc);
                rel_total++;
                check("release_pulse", {61'd0, t_ce, t_read, prev_rel}, 64'b110);
                check("release_after_block", {32'(issued), 32'(sent)}, {32'(BL), 32'(BL)});
`ifdef BLOCK_SUM_EN
                check("sum_at_release", {31'd0, sum_valid, sum_data}, {31'd0, 1'b1, blk_sum});
                last_sum = sum_data;
`endif
                issued = 0;
                sent = 0;
                blk_sum = '0;
            end
`ifdef BLOCK_SUM_EN
            else check("sum_quiet", {63'd0, sum_valid}, 64'd0);
`endif
            if (ce01) begin
                ce01_n++;
                check("bl1_addr", 64'(addr1), 64'd0);
            end
            if (valid1 && rdy1) begin
                hs1_n++;
                hs1_data = data1;
                hs1_last = last1;
            end
            if (ce1 && rd1s) begin
                rel1_n++;
`ifdef BLOCK_SUM_EN
                check("bl1_sum", {31'd0, sum1_valid, sum1_data}, {31'd0, 1'b1, 32'hDEADBEEF});
`endif
            end
            prev_rel = t_ce || t_read;
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
        end
        prev_reset = reset;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        ce0_cyc.delete();
        hs_cyc.delete();
        rel_cyc.delete();
        hs_data.delete();
        last_n = 0;
    endtask

    task automatic commit();
        int g = 0;
        while ((wr_cnt - rd_cnt) >= 2 && g < 200) begin
            step();
            g++;
        end
        if (g >= 200) check("commit_space_timeout", 64'd0, 64'd1);
        for (int i = 0; i < BL; i++) begin
            chan_mem[wr_cnt % 8][i] = blk_w[i];
            exp_q.push_back({(i == BL - 1) ? 1'b1 : 1'b0, blk_w[i]});
        end
        wr_cnt++;
    endtask

    task automatic wait_rel(input int n_more, input int budget);
        int target = rel_total + n_more;
        int g = 0;
        while (rel_total < target && g < budget) begin
            step();
            g++;
        end
        check("release_timeout", 64'(rel_total >= target), 64'd1);
        step();
    endtask

    // ---------------- stimulus ----------------
    int n0;
    int rel_before;
    int committed;

    initial begin
        repeat (3) step();
        reset = 1'b0;
        step();

        // Single block, free-flowing output.
        clear_log();
        for (int i = 0; i < BL; i++) blk_w[i] = DW'(10 + i);
        commit();
        n0 = cyc;
        wait_rel(1, 60);
        check("t1_ce0_count", 64'(ce0_cyc.size()), 64'd8);
        check("t1_first_ce0", 64'(ce0_cyc[0]), 64'(n0 + 1));
        check("t1_last_ce0", 64'(ce0_cyc[7]), 64'(n0 + 8));
        check("t1_first_out", 64'(hs_cyc[0]), 64'(n0 + 3));
        check("t1_last_out", 64'(hs_cyc[7]), 64'(n0 + 10));
        check("t1_release", 64'(rel_cyc[0]), 64'(n0 + 11));
        check("t1_word0", 64'(hs_data[0]), 64'd10);
        check("t1_word7", 64'(hs_data[7]), 64'd17);
        check("t1_last_count", 64'(last_n), 64'd1);

        // Backpressure for 20 cycles after the first valid word.
        clear_log();
        out_ready = 1'b0;
        commit();
        for (int g = 0; g < 20 && !out_valid; g++) step();
        check("t2_valid_seen", {63'd0, out_valid}, 64'd1);
        repeat (20) step();
        check("t2_ce0_count", 64'(ce0_cyc.size()), 64'd2);
        check("t2_head_hold", 64'(out_data), 64'd10);
        out_ready = 1'b1;
        wait_rel(1, 60);
        check("t2_words", 64'(hs_data.size()), 64'd8);
        check("t2_last_count", 64'(last_n), 64'd1);

        // Back-to-back buffers.
        clear_log();
        for (int i = 0; i < BL; i++) blk_w[i] = DW'(20 + i);
        commit();
        for (int i = 0; i < BL; i++) blk_w[i] = DW'(30 + i);
        commit();
        wait_rel(2, 80);
        check("t3_words", 64'(hs_data.size()), 64'd16);
        check("t3_last_count", 64'(last_n), 64'd2);
        check("t3_word8", 64'(hs_data[8]), 64'd30);
        check("t3_release_gap", 64'(rel_cyc[1] - rel_cyc[0]), 64'd12);
        check("t3_second_start", 64'(ce0_cyc[8]), 64'(rel_cyc[0] + 2));

        // BlockLen = 1 instance.
        wr1++;
        for (int g = 0; g < 20 && rel1_n < 1; g++) step();
        repeat (4) step();
        check("bl1_reads", 64'(ce01_n), 64'd1);
        check("bl1_words", 64'(hs1_n), 64'd1);
        check("bl1_data", 64'(hs1_data), 64'hDEADBEEF);
        check("bl1_last", {63'd0, hs1_last}, 64'd1);
        check("bl1_releases", 64'(rel1_n), 64'd1);

        // Reset in the middle of a block.
        clear_log();
        for (int i = 0; i < BL; i++) blk_w[i] = DW'(40 + i);
        commit();
        for (int g = 0; g < 40 && hs_data.size() < 3; g++) step();
        check("t5_three_out", 64'(hs_data.size() >= 3), 64'd1);
        rel_before = rel_total;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        exp_q.delete();
        step();
        check("t5_no_release", 64'(rel_total), 64'(rel_before));
        clear_log();
        for (int i = 0; i < BL; i++) blk_w[i] = DW'(50 + i);
        commit();
        wait_rel(1, 60);
        check("t5_ce0_count", 64'(ce0_cyc.size()), 64'd8);
        check("t5_word0", 64'(hs_data[0]), 64'd50);

`ifdef BLOCK_SUM_EN
        for (int i = 0; i < BL; i++) blk_w[i] = DW'(1 + i);
        commit();
        wait_rel(1, 60);
        check("sum_1_to_8", 64'(last_sum), 64'd36);
        for (int i = 0; i < BL; i++) blk_w[i] = (i < 2) ? 32'hFFFFFFFF : 32'h0;
        commit();
        wait_rel(1, 60);
        check("sum_wrap", 64'(last_sum), 64'hFFFFFFFE);
`endif

        // Randomized traffic with random backpressure.
        committed = 0;
        rel_before = rel_total;
        for (int c = 0; c < 600; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ((wr_cnt - rd_cnt) < 2 && committed < 14 && $urandom_range(0, 3) == 0) begin
                for (int i = 0; i < BL; i++) blk_w[i] = DW'($urandom());
                commit();
                committed++;
            end
            step();
        end
        out_ready = 1'b1;
        wait_rel((rel_before + committed) - rel_total, 200);
        check("rand_releases", 64'(rel_total - rel_before), 64'(committed));
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
